conv_layer_sched: RTL and testbench

Layer/tile scheduler that sequences the weight-loading controller and the MAC array through one complete three-layer convolution pass (conv00, conv02, conv04). For each layer it issues one weight-load request and waits for the weight controller to present that layer's kernels. It then launches that layer's compute tiles one at a time, handshaking each with the MAC array. After the last layer it issues a final load pulse so the weight controller returns to its start address.

---
 rtl/conv_layer_sched_if.sv | 27 ++
 rtl/conv_layer_sched.sv | 125 ++++++++++++
 tb/tb_conv_layer_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sched_if.sv
// Handshake bundle between the layer/tile scheduler and its environment.
// The master modport is the scheduler side. The slave modport is the
// weight controller / MAC array / host side.
interface conv_layer_sched_if #(
  parameter int unsigned TW = 12
);
  logic          i_start;
  logic          i_abort;
  logic          o_wload_en;
  logic          i_wready;
  logic          o_tile_start;
  logic          i_tile_done;
  logic [1:0]    o_layer_idx;
  logic [TW-1:0] o_tile_idx;
  logic          o_busy;
  logic          o_done;

  modport master (
    input  i_start, i_abort, i_wready, i_tile_done,
    output o_wload_en, o_tile_start, o_layer_idx, o_tile_idx, o_busy, o_done
  );

  modport slave (
    output i_start, i_abort, i_wready, i_tile_done,
    input  o_wload_en, o_tile_start, o_layer_idx, o_tile_idx, o_busy, o_done
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Three-layer convolution pass scheduler. For each layer it loads weights,
// waits for the weight controller's ready handshake, and then runs that
// layer's tiles one at a time. A final load pulse rewinds the weight
// controller at the end of the pass.
module conv_layer_sched #(
  parameter int unsigned L0_TILES = 4,
  parameter int unsigned L1_TILES = 43,
  parameter int unsigned L2_TILES = 171,
  parameter int unsigned TW       = 12
) (
  input  logic               clk,
  input  logic               rst,
  conv_layer_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WACK, S_WRDY, S_TSTART, S_TRUN, S_FIN, S_DONE
  } state_t;

  localparam logic [TW-1:0] LAST0 = TW'(L0_TILES - 1);
  localparam logic [TW-1:0] LAST1 = TW'(L1_TILES - 1);
  localparam logic [TW-1:0] LAST2 = TW'(L2_TILES - 1);

  state_t        state, state_nxt;
  logic [1:0]    layer_q, layer_nxt;
  logic [TW-1:0] tile_q, tile_nxt, tile_last;
  logic          wload_q, tstart_q, busy_q, done_q;
  logic          wload_nxt, tstart_nxt, busy_nxt, done_nxt;

  // Last tile index of the layer currently being processed
  always_comb begin
    unique case (layer_q)
      2'd0:    tile_last = LAST0;
      2'd1:    tile_last = LAST1;
      default: tile_last = LAST2;
    endcase
  end

  // State and layer/tile counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      layer_q <= '0;
      tile_q  <= '0;
    end else begin
      state   <= state_nxt;
      layer_q <= layer_nxt;
      tile_q  <= tile_nxt;
    end
  end

  // Next-state and counter update; abort overrides every other input
  always_comb begin
    state_nxt = state;
    layer_nxt = layer_q;
    tile_nxt  = tile_q;
    if (state != S_IDLE && bus.i_abort) begin
      state_nxt = S_IDLE;
      layer_nxt = '0;
      tile_nxt  = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            state_nxt = S_WLOAD;
            layer_nxt = '0;
            tile_nxt  = '0;
          end
        end
        S_WLOAD:  state_nxt = S_WACK;
        S_WACK:   if (!bus.i_wready) state_nxt = S_WRDY;
        S_WRDY:   if (bus.i_wready)  state_nxt = S_TSTART;
        S_TSTART: state_nxt = S_TRUN;
        S_TRUN: begin
          if (bus.i_tile_done) begin
            if (tile_q != tile_last) begin
              tile_nxt  = tile_q + TW'(1);
              state_nxt = S_TSTART;
            end else if (layer_q != 2'd2) begin
              layer_nxt = layer_q + 2'd1;
              tile_nxt  = '0;
              state_nxt = S_WLOAD;
            end else begin
              state_nxt = S_FIN;
            end
          end
        end
        S_FIN:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so that every pulse is registered
  always_comb begin
    wload_nxt  = (state_nxt == S_WLOAD) || (state_nxt == S_FIN);
    tstart_nxt = (state_nxt == S_TSTART);
    done_nxt   = (state_nxt == S_DONE);
    busy_nxt   = (state_nxt != S_IDLE);
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wload_q  <= 1'b0;
      tstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wload_q  <= wload_nxt;
      tstart_q <= tstart_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  assign bus.o_wload_en   = wload_q;
  assign bus.o_tile_start = tstart_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_layer_idx  = layer_q;
  assign bus.o_tile_idx   = tile_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched with 2/1/3 tiles per layer: a cycle vector
// table, fixed and randomized full passes against an event-sequence model,
// and abort/reset/back-to-back scenarios.
module tb_conv_layer_sched;
  localparam int unsigned TW = 12;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  conv_layer_sched_if #(.TW(TW)) bus ();

  conv_layer_sched #(
    .L0_TILES(2),
    .L1_TILES(1),
    .L2_TILES(3),
    .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        s, a, w, d;
    logic [17:0] exp;
  } vec_t;

  function automatic int unsigned ntiles(input int unsigned l);
    case (l)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic vec_t mk(input logic s, a, w, d, wl, ts,
                              input logic [1:0] l, input logic [11:0] t,
                              input logic b, dn);
    vec_t v;
    v.s = s; v.a = a; v.w = w; v.d = d;
    v.exp = {wl, ts, l, t, b, dn};
    return v;
  endfunction

  function automatic logic [17:0] outs();
    return {bus.o_wload_en, bus.o_tile_start, bus.o_layer_idx, bus.o_tile_idx,
            bus.o_busy, bus.o_done};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pass from IDLE with responder models. Events are encoded as
  // tile start = layer*256+tile, load pulse = 4096+that, done = 8192+that.
  task automatic run_pass(input bit rnd, input bit stop_l2);
    int exp_q[$];
    int got_q[$];
    int unsigned nwl = 0, nts = 0, wt = 0, wh = 1, wz = 1, cd = 0, tot = 0;
    int code;
    bit wact = 0, outst = 0, done_prev = 0, rise_prev = 0, finished = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      exp_q.push_back(4096 + int'(l) * 256);
      for (int unsigned t = 0; t < ntiles(l); t++) begin
        exp_q.push_back(int'(l) * 256 + int'(t));
        tot++;
      end
    end
    exp_q.push_back(4096 + 512 + int'(ntiles(2)) - 1);
    exp_q.push_back(8192 + 512 + int'(ntiles(2)) - 1);

    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int unsigned cyc = 0; cyc < 3000 && !finished; cyc++) begin
      code = int'(bus.o_layer_idx) * 256 + int'(bus.o_tile_idx);
      check("busy_in_pass", bus.o_busy, 1);
      if (done_prev) check("next_after_tile_done", bus.o_tile_start | bus.o_wload_en, 1);
      if (rise_prev) check("start_after_ready", bus.o_tile_start, 1);
      done_prev = 0;
      rise_prev = 0;
      if (bus.o_wload_en) begin
        got_q.push_back(4096 + code);
        nwl++;
        if (nwl <= 3) begin
          wact = 1;
          wt   = 0;
          wh   = rnd ? $urandom_range(1, 4) : 1;
          wz   = rnd ? $urandom_range(1, 3) : 1;
        end else begin
          wact = 0;
          bus.i_wready = 1'b0;
        end
      end
      if (bus.o_tile_start) begin
        got_q.push_back(code);
        nts++;
        if (stop_l2 && bus.o_layer_idx == 2'd2) begin
          bus.i_start = 1'b0;
          bus.i_tile_done = 1'b0;
          return;
        end
      end
      if (bus.o_done) begin
        got_q.push_back(8192 + code);
        finished = 1;
      end
      // weight controller: hold level, drop for a while, then raise
      if (wact) begin
        if (wt < wh) begin
        end else if (wt < wh + wz) begin
          bus.i_wready = 1'b0;
        end else begin
          bus.i_wready = 1'b1;
          wact = 0;
          rise_prev = 1;
        end
        wt++;
      end
      // MAC array: done some cycles after start, occasional ignored pulses
      if (bus.o_tile_start) begin
        outst = 1;
        cd = rnd ? $urandom_range(1, 6) : 5;
        bus.i_tile_done = rnd && ($urandom_range(0, 3) == 0);
      end else if (outst) begin
        cd--;
        if (cd == 0) begin
          bus.i_tile_done = 1'b1;
          outst = 0;
          done_prev = 1;
        end else begin
          bus.i_tile_done = 1'b0;
        end
      end else begin
        bus.i_tile_done = rnd && ($urandom_range(0, 7) == 0);
      end
      bus.i_start = rnd && !finished && ($urandom_range(0, 15) == 0);
      step();
    end
    bus.i_start = 1'b0;
    bus.i_tile_done = 1'b0;
    if (!finished) check("pass_timeout", 0, 1);
    check("idle_after_done", bus.o_busy, 0);
    check("single_done", bus.o_done, 0);
    check("wload_count", nwl, 4);
    check("tile_start_count", nts, tot);
    check("event_count", got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("event%0d", i), got_q[i], exp_q[i]);
  endtask

  vec_t tbl[21];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            s a w d  wl ts l t  b dn
    tbl[0]  = mk(1,0,0,0, 1,0,0,0, 1,0);
    tbl[1]  = mk(0,0,0,0, 0,0,0,0, 1,0);
    tbl[2]  = mk(0,0,0,0, 0,0,0,0, 1,0);
    tbl[3]  = mk(0,0,0,1, 0,0,0,0, 1,0);
    tbl[4]  = mk(0,0,1,0, 0,1,0,0, 1,0);
    tbl[5]  = mk(0,0,1,1, 0,0,0,0, 1,0);
    tbl[6]  = mk(0,0,1,0, 0,0,0,0, 1,0);
    tbl[7]  = mk(0,0,1,1, 0,1,0,1, 1,0);
    tbl[8]  = mk(0,0,1,0, 0,0,0,1, 1,0);
    tbl[9]  = mk(0,0,1,1, 1,0,1,0, 1,0);
    tbl[10] = mk(0,0,1,0, 0,0,1,0, 1,0);
    tbl[11] = mk(0,0,1,0, 0,0,1,0, 1,0);
    tbl[12] = mk(0,0,1,0, 0,0,1,0, 1,0);
    tbl[13] = mk(0,0,0,0, 0,0,1,0, 1,0);
    tbl[14] = mk(0,0,0,1, 0,0,1,0, 1,0);
    tbl[15] = mk(0,0,1,0, 0,1,1,0, 1,0);
    tbl[16] = mk(0,0,1,0, 0,0,1,0, 1,0);
    tbl[17] = mk(0,1,1,1, 0,0,0,0, 0,0);
    tbl[18] = mk(1,1,0,0, 0,0,0,0, 0,0);
    tbl[19] = mk(1,0,0,0, 1,0,0,0, 1,0);
    tbl[20] = mk(0,1,0,0, 0,0,0,0, 0,0);

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_wready = 1'b0;
    bus.i_tile_done = 1'b0;
    #12;
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    step();
    check("idle_after_reset", outs(), 0);

    // cycle table: handshake, spurious inputs, abort with tile done
    for (int unsigned i = 0; i < 21; i++) begin
      bus.i_start     = tbl[i].s;
      bus.i_abort     = tbl[i].a;
      bus.i_wready    = tbl[i].w;
      bus.i_tile_done = tbl[i].d;
      step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_wready = 1'b0;
    bus.i_tile_done = 1'b0;
    step();

    // fixed-latency pass, then an immediate back-to-back pass
    run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b0);

    for (int unsigned n = 0; n < 20; n++) run_pass(1'b1, 1'b0);

    // asynchronous reset while a layer-2 tile is running
    run_pass(1'b1, 1'b1);
    step();
    check("in_trun_l2", {bus.o_busy, bus.o_layer_idx}, 3'b110);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", outs(), 0);
    bus.i_wready = 1'b0;
    bus.i_tile_done = 1'b0;
    #10;
    rst = 1'b0;
    step();
    check("idle_after_midreset", outs(), 0);
    run_pass(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
